// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Parity build option: UART_TX_SCHED_PARITY_EN adds one bit per frame.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // start + stop bits around the data payload
   localparam int FRAME_BITS_BASE = 2;

`ifdef UART_TX_SCHED_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   function automatic int frame_bits(input int data_w);
      return data_w + FRAME_BITS_BASE + PARITY_BITS;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((int'(ptr) + off) % NUM_REQ);
         if (en && !any && req[idx]) begin
            any      = 1'b1;
            gnt_idx  = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART tx line among NUM_REQ requesters, one round-robin grant per frame.
// Build option UART_TX_SCHED_PARITY_EN inserts an even-parity bit before STOP.
//
// state  | meaning
// IDLE   | line high, arbitrating; accept moves to START
// START  | start bit (0)
// DATA   | DATA_W data bits, LSB first
// PARITY | even parity of latched data (parity builds only)
// STOP   | stop bit (1); end of frame pulses frame_done and returns to IDLE
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      tx,
   output logic                      frame_done
);

   localparam int FRAME_BITS = frame_bits(DATA_W);
   localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);

   uart_state_e         state;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic [ID_W-1:0]     rr_ptr;
`ifdef UART_TX_SCHED_PARITY_EN
   logic                parity_bit;
`endif

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [ID_W-1:0]     arb_idx;
   logic                arb_any;
   logic [DATA_W-1:0]   sel_data;
   logic [ID_W-1:0]     rr_next;
   logic                baud_tc;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .en      (state == IDLE),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   assign req_ready = arb_gnt;
   assign baud_tc   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign rr_next   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         grant_id   <= '0;
         rr_ptr     <= '0;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (arb_any) begin
               shreg    <= sel_data;
               grant_id <= arb_idx;
               rr_ptr   <= rr_next;
               tx       <= 1'b0;
               busy     <= 1'b1;
               state    <= START;
`ifdef UART_TX_SCHED_PARITY_EN
               parity_bit <= ^sel_data;
`endif
            end
         end else if (!baud_tc) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            // bit boundary: bit_cnt is 0 in START, 1..DATA_W across DATA
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            case (state)
               START: begin
                  state <= DATA;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
               end
               DATA: begin
                  if (bit_cnt == BIT_W'(DATA_W)) begin
`ifdef UART_TX_SCHED_PARITY_EN
                     state <= PARITY;
                     tx    <= parity_bit;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     tx    <= shreg[0];
                     shreg <= shreg >> 1;
                  end
               end
`ifdef UART_TX_SCHED_PARITY_EN
               PARITY: begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
`endif
               STOP: begin
                  state      <= IDLE;
                  tx         <= 1'b1;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART serial transmit line between NUM_REQ byte requesters.
- Round-robin arbitration grants the line per frame.
- The granted byte is latched, then framed LSB-first as: start bit (0), DATA_W data bits, stop bit (1).
- Sits between the per-channel message sources and the single tx pad, and owns all bit timing.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_W, 8, data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_W  requester i's data occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept strobe; at most one bit is high.
- grant_id  output  $clog2(NUM_REQ)  index of the requester whose frame is in flight or last sent.
- busy  output  1  high while a frame is on the line.
- tx  output  1  serial line; idles high.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async assert): tx=1, busy=0, req_ready=0, grant_id=0, frame_done=0, state=IDLE, bit and baud counters=0, rr pointer=0.
- The rr pointer is the highest-priority index. After reset, index 0 has top priority.
- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx = latched bit, LSB first.
  - STOP: tx=1.
  - PARITY (only when the optional feature is enabled): sits between DATA and STOP.
- Arbitration in IDLE, when any req_valid is high:
  - Pick the first asserted index scanning from rr pointer upward, modulo NUM_REQ.
  - In that same cycle, drive req_ready[g]=1 combinationally, latch req_data slice g, set grant_id=g, and set rr pointer=(g+1) mod NUM_REQ.
  - Next state is START.
- Handshake:
  - Transfer happens when req_valid[g] && req_ready[g] at a clock edge.
  - req_data is sampled only in the accept cycle.
  - A requester may drop req_valid at any time before it is accepted, with no side effects.
  - req_ready is never high outside IDLE.
- Timing:
  - Each of START, every DATA bit, PARITY and STOP lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
  - Tx changes only on state/bit boundaries.
- Latency:
  - Accept at cycle T gives START at T+1..T+CLKS_PER_BIT.
  - STOP occupies the final CLKS_PER_BIT cycles of the frame.
  - In the cycle after STOP ends: return to IDLE and pulse frame_done=1.
  - A new accept may occur in that same IDLE cycle, so the inter-frame gap is 1 cycle.
- busy is high from T+1 through the last STOP cycle.
- grant_id holds its value until the next accept.
- Simultaneous requests resolve purely by the rr pointer. The rr pointer advances only on accept.
- Reset mid-frame:
  - tx returns to 1 immediately and busy drops to 0.
  - No frame_done is produced; the partial frame is abandoned.
  - The rr pointer returns to 0.
- Requests that are asserted but never granted are not dropped. They are served within NUM_REQ frames, so there is no starvation.

Optional Feature:
- Macro: UART_TX_SCHED_PARITY_EN.
- Defined: a PARITY state follows DATA and transmits the XOR of the latched data bits (even parity), lasting CLKS_PER_BIT cycles. The frame becomes DATA_W+3 bits and frame_done shifts later by CLKS_PER_BIT cycles.
- Undefined: no PARITY state. The frame is DATA_W+2 bits.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constant FRAME_BITS_BASE=2.
- Sub-module uart_rr_arbiter (parameter NUM_REQ):
  - inputs: req, ptr, en;
  - outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational; the pointer register lives in the top level.
- The baud/bit counters and the shift register stay in uart_tx_scheduler.

Test Plan (NUM_REQ=4, CLKS_PER_BIT=4, DATA_W=8):
- Single request: req_valid=4'b0001, data0=0xA5, accepted at T → tx=0 at T+1..T+4; bits 1,0,1,0,0,1,0,1, each 4 cycles, at T+5..T+36; tx=1 at T+37..T+40; frame_done=1 at T+41 only; grant_id=0.
- All four requests held continuously → grant order 0,1,2,3,0. Each accept occurs in the frame_done cycle of the previous frame, so frame period is 41 cycles.
- Last grant=1, then req_valid=4'b1001 → grant 3; the next grant is 0.
- rst asserted at T+20 of a frame → tx=1 and busy=0 in the same cycle; no frame_done. After release, req_valid=4'b1010 grants 1.
- req_valid[2] pulsed for 3 cycles while busy, then dropped → never accepted; req_ready[2] stays 0; no extra frame.
- With UART_TX_SCHED_PARITY_EN defined, data=0x07 → parity bit=1 at T+37..T+40, STOP at T+41..T+44, frame_done at T+45.
